int_ctrl3: RTL and testbench

Three-line prioritized, nesting interrupt controller on the CPU side of the external break lines. It synchronizes and edge-detects `break1`..`break3` and latches pending requests. It raises `interrupt` to the CPU core and supplies the service vector on acknowledge. It tracks in-service levels until the CPU's interrupt return, producing the `IW*`/`ir*_sig` status the top level exposes.

---
 rtl/int_pkg.sv | 22 ++
 rtl/int_edge_sync.sv | 25 ++
 rtl/int_ctrl3.sv | 85 ++++++++
 tb/tb_int_ctrl3.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// int_pkg: line count, line index type and priority helpers shared by the int_ctrl3 slice.
package int_pkg;

    localparam int unsigned INT_LINES = 3;

    // 0 means "no line"; 1..INT_LINES name a break line.
    typedef logic [1:0] line_idx_t;

    function automatic line_idx_t prio_enc(input logic [INT_LINES-1:0] v);
        line_idx_t idx;
        idx = '0;
        for (int unsigned i = 0; i < INT_LINES; i++) begin
            if (v[i]) idx = line_idx_t'(i + 1);
        end
        return idx;
    endfunction

    function automatic logic [INT_LINES-1:0] line_mask(input line_idx_t k);
        return (k == '0) ? '0 : (INT_LINES'(1) << (k - 2'd1));
    endfunction

endpackage

// File: rtl/int_edge_sync.sv
// int_edge_sync: 2-flop synchronizer plus previous-value flop; pulses for one cycle per rising edge.
module int_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic req_line,
    output logic pulse
);

    logic sync1, sync2, prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= req_line;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/int_ctrl3.sv
// int_ctrl3: three-line prioritized interrupt controller with ack/eret handshake.
// Define INT_NEST_EN to let a higher line preempt a lower in-service line.
module int_ctrl3
    import int_pkg::*;
#(
    parameter logic [11:0] VEC_BASE   = 12'h100,
    parameter logic [11:0] VEC_STRIDE = 12'h010
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        break1,
    input  logic        break2,
    input  logic        break3,
    input  logic        int_en,
    input  logic        int_ack,
    input  logic        eret,
    input  logic        mask_we,
    input  logic [2:0]  mask_wdata,
    output logic        interrupt,
    output logic [11:0] vec_addr,
    output logic        IW1,
    output logic        IW2,
    output logic        IW3,
    output logic        ir1_sig,
    output logic        ir2_sig,
    output logic        ir3_sig
);

    logic [INT_LINES-1:0] breaks, edges, pending, mask, in_service;
    logic [INT_LINES-1:0] eligible, ack_clr, eret_clr;
    line_idx_t            cur, top;
    logic                 req, ack_take, eret_take;

    assign breaks = {break3, break2, break1};

    for (genvar g = 0; g < INT_LINES; g++) begin : g_sync
        int_edge_sync u_sync (
            .clk      (clk),
            .rst      (RST),
            .req_line (breaks[g]),
            .pulse    (edges[g])
        );
    end

    always_comb begin
        eligible  = int_en ? (pending & mask) : '0;
        top       = prio_enc(eligible);
        cur       = prio_enc(in_service);
`ifdef INT_NEST_EN
        req       = (top > cur);
`else
        req       = (top != '0) && (in_service == '0);
`endif
        eret_take = eret & (|in_service);
        // Ack only accepts a line still entitled to service, keeping in-service strictly nested.
        ack_take  = int_ack & interrupt & ~eret_take & req;
        ack_clr   = ack_take ? line_mask(top) : '0;
        eret_clr  = eret_take ? line_mask(cur) : '0;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            pending    <= '0;
            mask       <= '1;
            in_service <= '0;
            vec_addr   <= '0;
            interrupt  <= 1'b0;
        end else begin
            // A fresh edge on the acked line survives the clear.
            pending    <= (pending & ~ack_clr) | edges;
            in_service <= (in_service | ack_clr) & ~eret_clr;
            if (mask_we) mask <= mask_wdata;
            if (ack_take) vec_addr <= VEC_BASE + 12'(top - 2'd1) * VEC_STRIDE;
            interrupt  <= req & ~ack_take & ~eret_take;
        end
    end

    assign IW1     = pending[0];
    assign IW2     = pending[1];
    assign IW3     = pending[2];
    assign ir1_sig = in_service[0];
    assign ir2_sig = in_service[1];
    assign ir3_sig = in_service[2];

endmodule

// File: tb/tb_int_ctrl3.sv
// tb_int_ctrl3: directed and random checks of int_ctrl3 against a stack-based reference model.
module tb_int_ctrl3;

    localparam logic [11:0] BASE   = 12'h100;
    localparam logic [11:0] STRIDE = 12'h010;
`ifdef INT_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        RST, break1, break2, break3, int_en, int_ack, eret, mask_we;
    logic [2:0]  mask_wdata;
    logic        interrupt, IW1, IW2, IW3, ir1_sig, ir2_sig, ir3_sig;
    logic [11:0] vec_addr;

    int total = 0;
    int bad   = 0;

    // Reference model: pending flags, in-service lines as a nesting stack, break sample history.
    bit          m_pend[4];
    bit [2:0]    m_mask;
    int          m_stack[$];
    bit          m_irq;
    logic [11:0] m_vec;
    bit          m_hist[4][3];

    int_ctrl3 #(.VEC_BASE(BASE), .VEC_STRIDE(STRIDE)) dut (
        .clk(clk), .RST(RST), .break1(break1), .break2(break2), .break3(break3),
        .int_en(int_en), .int_ack(int_ack), .eret(eret), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .interrupt(interrupt), .vec_addr(vec_addr),
        .IW1(IW1), .IW2(IW2), .IW3(IW3),
        .ir1_sig(ir1_sig), .ir2_sig(ir2_sig), .ir3_sig(ir3_sig)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] obs();
        return {interrupt, vec_addr, IW3, IW2, IW1, ir3_sig, ir2_sig, ir1_sig};
    endfunction

    function automatic logic [18:0] expv();
        logic [2:0] iw, ir;
        ir = '0;
        for (int k = 1; k <= 3; k++) iw[k-1] = m_pend[k];
        foreach (m_stack[i]) ir[m_stack[i]-1] = 1'b1;
        return {m_irq, m_vec, iw, ir};
    endfunction

    // Advance the model by one clock using the inputs the DUT is about to sample, then clock.
    task automatic step();
        bit [3:0] brk;
        bit       edge_seen[4];
        int       top, cur;
        bit       eret_ok, ack_ok, entitled;
        brk = {break3, break2, break1, 1'b0};
        if (RST) begin
            for (int k = 1; k <= 3; k++) begin
                m_pend[k] = 0;
                for (int j = 0; j < 3; j++) m_hist[k][j] = 0;
            end
            m_stack.delete();
            m_mask = 3'b111;
            m_irq  = 0;
            m_vec  = '0;
        end else begin
            top = 0;
            for (int k = 1; k <= 3; k++)
                if (m_pend[k] && m_mask[k-1] && int_en) top = k;
            cur      = (m_stack.size() == 0) ? 0 : m_stack[$];
            entitled = NEST ? (top > cur) : (top != 0 && m_stack.size() == 0);
            eret_ok  = eret && (m_stack.size() > 0);
            ack_ok   = int_ack && m_irq && !eret_ok && entitled;
            for (int k = 1; k <= 3; k++) edge_seen[k] = m_hist[k][1] && !m_hist[k][2];
            if (ack_ok) begin
                m_pend[top] = 0;
                m_stack.push_back(top);
                m_vec = BASE + 12'(top - 1) * STRIDE;
            end
            for (int k = 1; k <= 3; k++) if (edge_seen[k]) m_pend[k] = 1;
            if (eret_ok) void'(m_stack.pop_back());
            m_irq = (ack_ok || eret_ok) ? 1'b0 : entitled;
            if (mask_we) m_mask = mask_wdata;
            for (int k = 1; k <= 3; k++) begin
                m_hist[k][2] = m_hist[k][1];
                m_hist[k][1] = m_hist[k][0];
                m_hist[k][0] = brk[k];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_breaks(input logic [2:0] b, input int n);
        {break3, break2, break1} = b;
        repeat (n) step();
        {break3, break2, break1} = 3'b000;
        repeat (2) step();
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1; step(); int_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1; step(); eret = 1'b0;
    endtask

    task automatic wait_irq(input string name);
        int n = 0;
        while (interrupt !== 1'b1 && n < 12) begin step(); n++; end
        total++;
        if (interrupt !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout interrupt=%b required=1", name, interrupt);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; step(); step(); RST = 1'b0;
        total++;
        if (obs() !== 19'h0) begin bad++; $display("FAIL reset outputs=%h required=0", obs()); end
    endtask

    task automatic test_single();
        int_en = 1'b1;
        break1 = 1'b1;
        step(); step(); step();
        total++;
        if ({IW1, interrupt} !== 2'b10) begin bad++; $display("FAIL single_iw IW1,irq=%b required=10", {IW1, interrupt}); end
        step();
        total++;
        if (interrupt !== 1'b1) begin bad++; $display("FAIL single_irq got=%b required=1", interrupt); end
        break1 = 1'b0;
        pulse_ack();
        total++;
        if ({vec_addr, ir1_sig, IW1, interrupt} !== {12'h100, 3'b100}) begin
            bad++; $display("FAIL single_ack vec=%h ir1=%b IW1=%b irq=%b required 100/1/0/0", vec_addr, ir1_sig, IW1, interrupt);
        end
        step(); step();
        total++;
        if (obs() !== expv()) begin bad++; $display("FAIL single_model got=%h exp=%h", obs(), expv()); end
        pulse_eret();
        total++;
        if (ir1_sig !== 1'b0) begin bad++; $display("FAIL single_eret ir1=%b required=0", ir1_sig); end
    endtask

    task automatic test_priority();
        logic [11:0] want[3] = '{12'h120, 12'h110, 12'h100};
        logic [2:0]  wir[3]  = '{3'b100, 3'b010, 3'b001};
        pulse_breaks(3'b111, 3);
        for (int i = 0; i < 3; i++) begin
            wait_irq("prio");
            pulse_ack();
            total++;
            if ({vec_addr, ir3_sig, ir2_sig, ir1_sig} !== {want[i], wir[i]}) begin
                bad++; $display("FAIL prio_ack%0d vec=%h ir=%b required %h/%b", i, vec_addr, {ir3_sig, ir2_sig, ir1_sig}, want[i], wir[i]);
            end
            pulse_eret();
        end
        total++;
        if (obs() !== expv()) begin bad++; $display("FAIL prio_model got=%h exp=%h", obs(), expv()); end
    endtask

    task automatic test_nesting();
        pulse_breaks(3'b001, 3);
        wait_irq("nest_first");
        pulse_ack();
        pulse_breaks(3'b100, 3);
`ifdef INT_NEST_EN
        wait_irq("nest_preempt");
        pulse_ack();
        total++;
        if ({vec_addr, ir3_sig, ir2_sig, ir1_sig} !== {12'h120, 3'b101}) begin
            bad++; $display("FAIL nest_ack vec=%h ir=%b required 120/101", vec_addr, {ir3_sig, ir2_sig, ir1_sig});
        end
        pulse_eret();
        total++;
        if ({ir3_sig, ir2_sig, ir1_sig} !== 3'b001) begin bad++; $display("FAIL nest_eret ir=%b required=001", {ir3_sig, ir2_sig, ir1_sig}); end
        pulse_eret();
`else
        begin
            bit seen = 1'b0;
            repeat (6) begin step(); if (interrupt !== 1'b0) seen = 1'b1; end
            total++;
            if (seen || IW3 !== 1'b1) begin bad++; $display("FAIL nonest_hold irq_seen=%b IW3=%b required 0/1", seen, IW3); end
        end
        pulse_eret();
        total++;
        if (ir1_sig !== 1'b0) begin bad++; $display("FAIL nonest_eret ir1=%b required=0", ir1_sig); end
        wait_irq("nonest_after");
        pulse_ack();
        total++;
        if ({vec_addr, ir3_sig, ir2_sig, ir1_sig} !== {12'h120, 3'b100}) begin
            bad++; $display("FAIL nonest_ack vec=%h ir=%b required 120/100", vec_addr, {ir3_sig, ir2_sig, ir1_sig});
        end
        pulse_eret();
`endif
        total++;
        if (obs() !== expv()) begin bad++; $display("FAIL nest_model got=%h exp=%h", obs(), expv()); end
    endtask

    task automatic test_mask();
        mask_we = 1'b1; mask_wdata = 3'b101; step(); mask_we = 1'b0;
        pulse_breaks(3'b010, 3);
        step(); step();
        total++;
        if ({IW2, interrupt} !== 2'b10) begin bad++; $display("FAIL mask_hold IW2,irq=%b required=10", {IW2, interrupt}); end
        mask_we = 1'b1; mask_wdata = 3'b111; step(); mask_we = 1'b0;
        step();
        total++;
        if (interrupt !== 1'b1) begin bad++; $display("FAIL mask_unmask irq=%b required=1", interrupt); end
        pulse_ack();
        total++;
        if (vec_addr !== 12'h110) begin bad++; $display("FAIL mask_ack vec=%h required=110", vec_addr); end
        pulse_eret();
    endtask

    task automatic test_ack_eret();
        pulse_breaks(3'b001, 3);
        wait_irq("ackeret_first");
        pulse_ack();
        pulse_breaks(3'b010, 3);
        step();
        int_ack = 1'b1; eret = 1'b1; step(); int_ack = 1'b0; eret = 1'b0;
        total++;
        if ({vec_addr, IW2, ir3_sig, ir2_sig, ir1_sig} !== {12'h100, 4'b1000}) begin
            bad++; $display("FAIL ack_eret vec=%h IW2=%b ir=%b required 100/1/000", vec_addr, IW2, {ir3_sig, ir2_sig, ir1_sig});
        end
        wait_irq("ackeret_reack");
        pulse_ack();
        total++;
        if (vec_addr !== 12'h110) begin bad++; $display("FAIL ack_eret_reack vec=%h required=110", vec_addr); end
        pulse_eret();
    endtask

    task automatic test_reset_mid();
        pulse_breaks(3'b001, 3);
        wait_irq("rstmid_first");
        pulse_ack();
        pulse_breaks(3'b010, 3);
        mask_we = 1'b1; mask_wdata = 3'b010; step(); mask_we = 1'b0;
        RST = 1'b1; step(); RST = 1'b0;
        total++;
        if (obs() !== 19'h0) begin bad++; $display("FAIL reset_mid outputs=%h required=0", obs()); end
        pulse_breaks(3'b001, 3);
        wait_irq("rstmid_mask");
        pulse_ack();
        total++;
        if (obs() !== expv()) begin bad++; $display("FAIL reset_mid_model got=%h exp=%h", obs(), expv()); end
        pulse_eret();
    endtask

    task automatic test_random();
        int hold[3] = '{0, 0, 0};
        logic [2:0] b = 3'b000;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (hold[k] == 0) begin
                    if ($urandom_range(1, 0) == 1) b[k] = ~b[k];
                    hold[k] = $urandom_range(5, 2);
                end else hold[k]--;
            end
            {break3, break2, break1} = b;
            int_en     = ($urandom_range(7, 0) != 0);
            int_ack    = ($urandom_range(2, 0) == 0);
            eret       = ($urandom_range(5, 0) == 0);
            mask_we    = ($urandom_range(19, 0) == 0);
            mask_wdata = 3'($urandom);
            RST        = ($urandom_range(299, 0) == 0);
            step();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL random_c%0d got=%h exp=%h", c, obs(), expv()); end
        end
        {break3, break2, break1} = 3'b000;
        {int_ack, eret, mask_we, RST} = 4'b0000;
    endtask

    initial begin
        {RST, break1, break2, break3, int_en, int_ack, eret, mask_we} = 8'b1000_0000;
        mask_wdata = 3'b111;
        test_reset();
        test_single();
        test_priority();
        test_nesting();
        test_mask();
        test_ack_eret();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
